piso_serializer: RTL and testbench

Parallel-in serial-out serializer: accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock. It is the transmit-side counterpart of the existing serial-in parallel-out shifter (sipo_shifter). With MSB_FIRST=1, `so` wired to that shifter's serial input reproduces each word on its parallel output. A one-entry holding register allows back-to-back words with no idle bit between them.

---
 rtl/piso_serializer.sv | 130 +++++++++++++
 tb/tb_piso_serializer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in serial-out serializer. Accepts WIDTH-bit words
//                over a valid/ready handshake and emits them one bit per
//                clock. A one-entry holding register lets consecutive words
//                stream without an idle bit between them.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

    localparam int               c_CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [0:0]       c_IDLE     = 1'b0;
    localparam logic [0:0]       c_SHIFT    = 1'b1;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_sreg;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_hold;
    logic               r_hold_full;

    logic [0:0]         w_state_nxt;
    logic [WIDTH-1:0]   w_sreg_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]   w_hold_nxt;
    logic               w_hold_full_nxt;

    logic               w_xfer;
    logic               w_end_of_word;
    logic [WIDTH-1:0]   w_shifted;

    // Bit order only changes which end of sreg faces the output.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_sreg[WIDTH-2:0], 1'b0};
            assign so        = r_sreg[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, r_sreg[WIDTH-1:1]};
            assign so        = r_sreg[0];
        end
    endgenerate

    // Ready is masked during reset so no word is taken while state is cleared.
    assign din_ready     = !r_hold_full && !rst;
    assign w_xfer        = din_valid && din_ready;
    assign w_end_of_word = (r_state == c_SHIFT) && (r_cnt == c_CNT_LAST);

    assign so_valid = (r_state == c_SHIFT);
    assign so_last  = w_end_of_word;
    assign busy     = so_valid || r_hold_full;

    // Next-state logic: word routing, shifting and end-of-word handover.
    always_comb begin
        w_state_nxt     = r_state;
        w_sreg_nxt      = r_sreg;
        w_cnt_nxt       = r_cnt;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        case (r_state)
            c_IDLE: begin
                if (w_xfer) begin
                    w_sreg_nxt  = din;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_SHIFT;
                end
            end
            c_SHIFT: begin
                if (!w_end_of_word) begin
                    w_sreg_nxt = w_shifted;
                    w_cnt_nxt  = r_cnt + 1'b1;
                    if (w_xfer) begin
                        w_hold_nxt      = din;
                        w_hold_full_nxt = 1'b1;
                    end
                end else if (r_hold_full) begin
                    // Ready is low here, so no transfer can collide with the drain.
                    w_sreg_nxt      = r_hold;
                    w_hold_full_nxt = 1'b0;
                    w_cnt_nxt       = '0;
                end else if (w_xfer) begin
                    w_sreg_nxt = din;
                    w_cnt_nxt  = '0;
                end else begin
                    // sreg is kept zero in IDLE so so reads 0 there.
                    w_sreg_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_sreg_nxt  = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State register; reset discards both the word in flight and any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_sreg      <= '0;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sreg      <= w_sreg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_serializer
//  Description : Directed self-checking bench for piso_serializer (MSB-first
//                and LSB-first instances plus a behavioural receive shifter).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din = 4'h0;
    logic       din_valid = 1'b0;
    logic       din_ready, so, so_valid, so_last, busy;

    logic [3:0] din_l = 4'h0;
    logic       din_valid_l = 1'b0;
    logic       din_ready_l, so_l, so_valid_l, so_last_l, busy_l;

    logic [3:0] r_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .so(so), .so_valid(so_valid),
        .so_last(so_last), .busy(busy)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din(din_l), .din_valid(din_valid_l),
        .din_ready(din_ready_l), .so(so_l), .so_valid(so_valid_l),
        .so_last(so_last_l), .busy(busy_l)
    );

    // Receive-side shifter: serial bit enters at the LSB, MSB-first word order.
    always_ff @(posedge clk) begin
        if (rst) r_q <= 4'h0;
        else     r_q <= {r_q[2:0], so};
    end

    task automatic test_reset();
        rst = 1'b1; din = 4'hF; din_valid = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        checks++;
        if ({so, so_valid, so_last, busy, din_ready} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs: got so/vld/last/busy/rdy=%b expected 00000",
                     {so, so_valid, so_last, busy, din_ready});
        end
        rst = 1'b0; din_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", din_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (so_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_tx: cycle %0d got so_valid=%b busy=%b expected 0 0",
                         i, so_valid, busy);
            end
        end
    endtask

    task automatic test_single_word();
        logic [3:0] exp_bits;
        exp_bits = 4'b1011;
        @(posedge clk); #1;
        din = 4'b1011; din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++;
            if (so !== exp_bits[3-j] || so_valid !== 1'b1 || so_last !== (j == 3)) begin
                errors++;
                $display("FAIL single_bit%0d: got so=%b vld=%b last=%b expected %b 1 %b",
                         j, so, so_valid, so_last, exp_bits[3-j], (j == 3));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (so !== 1'b0 || so_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got so=%b vld=%b busy=%b expected 0 0 0",
                     so, so_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_bits;
        logic       exp_rdy;
        exp_bits = 8'b1010_0101;
        @(posedge clk); #1;
        din = 4'hA; din_valid = 1'b1;
        @(posedge clk); #1;
        din = 4'h5;
        for (int j = 0; j < 8; j++) begin
            exp_rdy = !(j >= 1 && j <= 3);
            @(negedge clk);
            checks++;
            if (so !== exp_bits[7-j] || so_valid !== 1'b1 ||
                so_last !== (j == 3 || j == 7) || din_ready !== exp_rdy) begin
                errors++;
                $display("FAIL b2b_bit%0d: got so=%b vld=%b last=%b rdy=%b expected %b 1 %b %b",
                         j, so, so_valid, so_last, din_ready, exp_bits[7-j],
                         (j == 3 || j == 7), exp_rdy);
            end
            @(posedge clk); #1;
            if (j == 0) din_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (so_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got vld=%b busy=%b expected 0 0", so_valid, busy);
        end
    endtask

    task automatic test_direct_reload();
        logic [7:0] exp_bits;
        exp_bits = 8'b1100_0011;
        @(posedge clk); #1;
        din = 4'hC; din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            // Offer the next word only during the last-bit cycle.
            if (j == 3) begin din = 4'h3; din_valid = 1'b1; end
            @(negedge clk);
            checks++;
            if (so !== exp_bits[7-j] || so_valid !== 1'b1 ||
                so_last !== (j == 3 || j == 7) || din_ready !== 1'b1) begin
                errors++;
                $display("FAIL reload_bit%0d: got so=%b vld=%b last=%b rdy=%b expected %b 1 %b 1",
                         j, so, so_valid, so_last, din_ready, exp_bits[7-j], (j == 3 || j == 7));
            end
            @(posedge clk); #1;
            din_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (so_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reload_idle: got vld=%b busy=%b expected 0 0", so_valid, busy);
        end
    endtask

    task automatic test_lsb_first();
        logic [3:0] exp_bits;
        exp_bits = 4'b1011;
        @(posedge clk); #1;
        din_l = 4'b1011; din_valid_l = 1'b1;
        @(posedge clk); #1;
        din_valid_l = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++;
            if (so_l !== exp_bits[j] || so_valid_l !== 1'b1 || so_last_l !== (j == 3)) begin
                errors++;
                $display("FAIL lsb_bit%0d: got so=%b vld=%b last=%b expected %b 1 %b",
                         j, so_l, so_valid_l, so_last_l, exp_bits[j], (j == 3));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (so_l !== 1'b0 || so_valid_l !== 1'b0 || busy_l !== 1'b0) begin
            errors++;
            $display("FAIL lsb_idle: got so=%b vld=%b busy=%b expected 0 0 0",
                     so_l, so_valid_l, busy_l);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_bits;
        exp_bits = 4'b0110;
        @(posedge clk); #1;
        din = 4'hF; din_valid = 1'b1;
        @(posedge clk); #1;
        din = 4'h3;
        @(negedge clk);
        checks++;
        if (so !== 1'b1 || so_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_bit0: got so=%b vld=%b expected 1 1", so, so_valid);
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (so !== 1'b1 || busy !== 1'b1 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_bit1: got so=%b busy=%b rdy=%b expected 1 1 0",
                     so, busy, din_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (so_valid !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1 || so !== 1'b0) begin
            errors++;
            $display("FAIL mid_after_rst: got vld=%b busy=%b rdy=%b so=%b expected 0 0 1 0",
                     so_valid, busy, din_ready, so);
        end
        din = 4'h6; din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++;
            if (so !== exp_bits[3-j] || so_valid !== 1'b1) begin
                errors++;
                $display("FAIL mid_word6_bit%0d: got so=%b vld=%b expected %b 1",
                         j, so, so_valid, exp_bits[3-j]);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (so_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_stale: cycle %0d got vld=%b busy=%b expected 0 0",
                         i, so_valid, busy);
            end
        end
    endtask

    task automatic test_loopback();
        @(posedge clk); #1;
        din = 4'b0110; din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (r_q !== 4'b0110) begin
            errors++;
            $display("FAIL loopback_q: got %b expected 0110", r_q);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_direct_reload();
        test_lsb_first();
        test_reset_mid();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
